// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: drives the LED bar with the guess-progress bar in idle,
// or a timed win flash / lose sweep when game control requests one.
module led_pattern_sequencer #(
    parameter int TICK_DIV    = 5000000,
    parameter int WIN_FLASHES = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       won,
    input  logic       lost,
    input  logic [3:0] guess_count,
    output logic [9:0] LEDR,
    output logic       busy,
    output logic       done
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int FW = WIN_FLASHES > 1 ? $clog2(WIN_FLASHES) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(WIN_FLASHES - 1);

    typedef enum logic [1:0] {IDLE, WIN_ON, WIN_OFF, LOSE_SWEEP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [3:0]    step_q, step_d;
    logic [9:0]    led_q, led_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          phase_end, last_flash, last_step;

    // Thermometer code; counts of 10 and above light the whole bar.
    function automatic logic [9:0] therm(input logic [3:0] n);
        return n >= 4'd10 ? 10'h3FF : 10'((11'd1 << n) - 11'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            flash_q <= '0;
            step_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            flash_q <= flash_d;
            step_q  <= step_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        phase_end  = tick_q == TICK_MAX;
        last_flash = flash_q == FLASH_MAX;
        last_step  = step_q == 4'd9;
        state_d    = state_q;
        case (state_q)
            IDLE:       state_d = won ? WIN_ON : lost ? LOSE_SWEEP : IDLE;
            WIN_ON:     state_d = phase_end ? WIN_OFF : WIN_ON;
            WIN_OFF:    if (phase_end) state_d = last_flash ? IDLE : WIN_ON;
            LOSE_SWEEP: if (phase_end && last_step) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        tick_d  = (state_q == IDLE || phase_end) ? '0 : tick_q + TW'(1);
        flash_d = state_q == IDLE ? '0 :
                  (state_q == WIN_OFF && phase_end && !last_flash) ? flash_q + FW'(1) : flash_q;
        step_d  = state_q == IDLE ? '0 :
                  (state_q == LOSE_SWEEP && phase_end && !last_step) ? step_q + 4'd1 : step_q;
    end

    always_comb begin
        led_d = led_q;
        case (state_q)
            IDLE:       led_d = won ? 10'h3FF : lost ? 10'h200 : therm(guess_count);
            WIN_ON:     if (phase_end) led_d = 10'h000;
            WIN_OFF:    if (phase_end) led_d = last_flash ? therm(guess_count) : 10'h3FF;
            LOSE_SWEEP: if (phase_end) led_d = last_step ? therm(guess_count) : led_q >> 1;
            default:    led_d = 10'h000;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_q != IDLE && state_d == IDLE;
    end

    assign LEDR = led_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
